// File: rtl/lenet_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lenet_pkg
//  Description : Shared constants, FSM state encoding and argmax candidate
//                type for the LeNet classification readout stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package lenet_pkg;

    localparam int CLASS_NUM              = 10;
    localparam int DATA_WIDTH             = 8;
    localparam int DATA_NUM_PER_SRAM_ADDR = 4;
    localparam int F_WORDS                = (CLASS_NUM + DATA_NUM_PER_SRAM_ADDR - 1)
                                            / DATA_NUM_PER_SRAM_ADDR;
    localparam int CLASS_W                = 4;

    // Readout sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // One argmax candidate: valid flag, class index and raw signed score bits
    typedef struct packed {
        logic                  vld;
        logic [CLASS_W-1:0]    cls;
        logic [DATA_WIDTH-1:0] score;
    } cand_t;

    // Return the larger candidate; b wins only when strictly greater, so the
    // left (lower class index) operand is kept on ties.
    function automatic cand_t pick_max(input cand_t a, input cand_t b);
        cand_t r;
        r = a;
        if (b.vld && (!a.vld || ($signed(b.score) > $signed(a.score)))) begin
            r = b;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/argmax_unit.sv
`default_nettype none
// ============================================================================
//  Module      : argmax_unit
//  Description : Per-set running argmax. Masks lanes beyond the last class,
//                reduces one SRAM word with a 4-lane signed max tree and folds
//                the word winner into a running max register.
//  Revision    : 1.0 - initial release
// ============================================================================
module argmax_unit
    import lenet_pkg::*;
#(
    parameter int ADDR_WIDTH = 2
) (
    input  logic                                     clk,
    input  logic                                     srst,
    input  logic                                     i_en,
    input  logic                                     i_init,
    input  logic [ADDR_WIDTH-1:0]                    i_word_idx,
    input  logic [DATA_NUM_PER_SRAM_ADDR*DATA_WIDTH-1:0] i_word,
    output logic [CLASS_W-1:0]                       o_max_class,
    output logic [DATA_WIDTH-1:0]                    o_max_score
);

    localparam int c_LANES = DATA_NUM_PER_SRAM_ADDR;

    cand_t w_lane [c_LANES];
    cand_t w_pair_lo;
    cand_t w_pair_hi;
    cand_t w_word_best;
    cand_t w_base;
    cand_t w_next;
    cand_t r_max;

    // Lane 0 sits in the most significant byte; class = word*lanes + lane
    generate
        for (genvar gl = 0; gl < c_LANES; gl++) begin : g_lane
            assign w_lane[gl] = {
                ((int'(i_word_idx) * c_LANES + gl) < CLASS_NUM),
                CLASS_W'(int'(i_word_idx) * c_LANES + gl),
                i_word[(c_LANES-1-gl)*DATA_WIDTH +: DATA_WIDTH]
            };
        end
    endgenerate

    // Two-level tree; left operands carry the lower class indices
    assign w_pair_lo   = pick_max(w_lane[0], w_lane[1]);
    assign w_pair_hi   = pick_max(w_lane[2], w_lane[3]);
    assign w_word_best = pick_max(w_pair_lo, w_pair_hi);

    // On the first word the running max restarts from lane 0 of that word
    assign w_base = i_init ? w_lane[0] : r_max;
    assign w_next = pick_max(w_base, w_word_best);

    // Running max register, updated once per arriving word
    always_ff @(posedge clk) begin
        if (srst) begin
            r_max <= '0;
        end else if (i_en) begin
            r_max <= w_next;
        end
    end

    assign o_max_class = r_max.cls;
    assign o_max_score = r_max.score;

endmodule
`default_nettype wire

// File: rtl/lenet_argmax.sv
`default_nettype none
// ============================================================================
//  Module      : lenet_argmax
//  Description : Classification readout. On fc2_done, reads both SRAM F sets,
//                finds the signed argmax of each and hands the two results to
//                the host over a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module lenet_argmax
    import lenet_pkg::*;
#(
    parameter int DATA_WIDTH             = 8,
    parameter int DATA_NUM_PER_SRAM_ADDR = 4,
    parameter int CLASS_NUM              = 10,
    parameter int ADDR_WIDTH             = 2
) (
    input  logic                                          clk,
    input  logic                                          srst,
    input  logic                                          fc2_done,
    output logic [ADDR_WIDTH-1:0]                         sram_raddr_f,
    input  logic [DATA_NUM_PER_SRAM_ADDR*DATA_WIDTH-1:0]  sram_rdata_f,
    input  logic [DATA_NUM_PER_SRAM_ADDR*DATA_WIDTH-1:0]  sram_rdata_f_1,
    output logic                                          result_valid,
    input  logic                                          result_ready,
    output logic [3:0]                                    result_class0,
    output logic [3:0]                                    result_class1,
    output logic [DATA_WIDTH-1:0]                         result_score0,
    output logic [DATA_WIDTH-1:0]                         result_score1,
    output logic                                          busy,
    output logic                                          overrun
);

    localparam int c_F_WORDS = (CLASS_NUM + DATA_NUM_PER_SRAM_ADDR - 1)
                               / DATA_NUM_PER_SRAM_ADDR;
    localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = ADDR_WIDTH'(c_F_WORDS - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_rd_vld;
    logic [ADDR_WIDTH-1:0] r_rd_idx;
    logic                  r_overrun;
    logic                  w_last_addr;
    logic                  w_init;

    assign w_last_addr = (r_addr == c_LAST_ADDR);

    // State register
    always_ff @(posedge clk) begin
        if (srst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (fc2_done)     w_state_nxt = ST_READ;
            ST_READ:  if (w_last_addr)  w_state_nxt = ST_DRAIN;
            ST_DRAIN:                   w_state_nxt = ST_DONE;
            ST_DONE:  if (result_ready) w_state_nxt = ST_IDLE;
            default:                    w_state_nxt = ST_IDLE;
        endcase
    end

    // Address counter plus a one-cycle shadow that tags returning read data
    always_ff @(posedge clk) begin
        if (srst) begin
            r_addr   <= '0;
            r_rd_vld <= 1'b0;
            r_rd_idx <= '0;
        end else begin
            r_rd_vld <= (r_state == ST_READ);
            r_rd_idx <= r_addr;
            if ((r_state == ST_IDLE) && fc2_done) begin
                r_addr <= '0;
            end else if ((r_state == ST_READ) && !w_last_addr) begin
                r_addr <= r_addr + ADDR_WIDTH'(1);
            end
        end
    end

    // Sticky flag: a start request arrived while a readout was in progress
    always_ff @(posedge clk) begin
        if (srst) begin
            r_overrun <= 1'b0;
        end else if (fc2_done && (r_state != ST_IDLE)) begin
            r_overrun <= 1'b1;
        end
    end

    assign w_init = r_rd_vld && (r_rd_idx == '0);

    argmax_unit #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_set0 (
        .clk         (clk),
        .srst        (srst),
        .i_en        (r_rd_vld),
        .i_init      (w_init),
        .i_word_idx  (r_rd_idx),
        .i_word      (sram_rdata_f),
        .o_max_class (result_class0),
        .o_max_score (result_score0)
    );

    argmax_unit #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_set1 (
        .clk         (clk),
        .srst        (srst),
        .i_en        (r_rd_vld),
        .i_init      (w_init),
        .i_word_idx  (r_rd_idx),
        .i_word      (sram_rdata_f_1),
        .o_max_class (result_class1),
        .o_max_score (result_score1)
    );

    assign sram_raddr_f = r_addr;
    assign result_valid = (r_state == ST_DONE);
    assign busy         = (r_state != ST_IDLE);
    assign overrun      = r_overrun;

endmodule
`default_nettype wire

// File: doc/lenet_argmax.md
# lenet_argmax

Classification readout stage downstream of the dual-set LeNet core. On each `fc2_done` pulse it reads the ten FC2 output scores of both image sets from SRAM F (set 0 and set 1 share one read address) and finds the signed maximum of each set. It then presents the two winning class indices and scores to the host through a valid/ready handshake. It is the last stage before results leave the accelerator.

## Interface
- `DATA_WIDTH`, 8, width of one signed score
- `DATA_NUM_PER_SRAM_ADDR`, 4, scores per SRAM F word
- `CLASS_NUM`, 10, number of valid scores per set
- `ADDR_WIDTH`, 2, SRAM F address width (matches `sram_waddr_f`)

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `srst`  in  1  synchronous, active-high reset
- `fc2_done`  in  1  one-cycle pulse from the core: SRAM F holds final scores
- `sram_raddr_f`  out  ADDR_WIDTH  read address, shared by both SRAM F sets
- `sram_rdata_f`  in  DATA_NUM_PER_SRAM_ADDR*DATA_WIDTH  set-0 read data
- `sram_rdata_f_1`  in  DATA_NUM_PER_SRAM_ADDR*DATA_WIDTH  set-1 read data
- `result_valid`  out  1  result available
- `result_ready`  in  1  host accepts result
- `result_class0`  out  4  set-0 winning class, 0–9
- `result_class1`  out  4  set-1 winning class, 0–9
- `result_score0`  out  DATA_WIDTH  set-0 winning score, signed
- `result_score1`  out  DATA_WIDTH  set-1 winning score, signed
- `busy`  out  1  high from READ through DONE
- `overrun`  out  1  sticky: `fc2_done` arrived while busy

## Operation
- Score layout:
  - Class k is in word k/4, lane k%4.
  - Lane 0 = bits [31:24], lane 3 = bits [7:0].
  - Word 2 lanes 2–3 are unused and are ignored.
- SRAM read latency is 1 cycle: data for the address driven in cycle n is valid in cycle n+1.
- FSM states:
  - IDLE: when `fc2_done`=1, go to READ.
  - READ: drive addresses 0, 1, 2 on consecutive cycles, then go to DRAIN.
  - DRAIN: capture the last word, then go to DONE.
  - DONE: hold `result_valid`=1 until `result_valid && result_ready`, then go to IDLE.
- Per set, running max register (score + index):
  - Initialised from word 0 lane 0.
  - Each arriving word: find the 4-lane max combinationally, then compare it with the running max.
  - Compare is signed two's complement. Replace only on strictly greater, so on ties the lowest class index wins.
  - Classes ≥ CLASS_NUM are masked out.
- `fc2_done` seen while busy: ignored, and `overrun` is set. `overrun` is cleared only by `srst`.
- Result outputs stay stable while `result_valid`=1.

## Timing
- Reset values:
  - FSM = IDLE, `sram_raddr_f`=0.
  - `result_valid`=0, `busy`=0, `overrun`=0.
  - Classes=0, scores=0.
- `srst` mid-operation aborts immediately. The partial max is discarded and no `result_valid` is produced.
- Cycle t: `fc2_done`=1 in IDLE.
- t+1: `sram_raddr_f`=0, `busy`=1.
- t+2: word 0 compared, addr=1.
- t+3: word 1 compared, addr=2.
- t+4: word 2 compared.
- t+5: `result_valid`=1. Fixed latency is 5 cycles.
- Handshake: if `result_ready`=1 at t+5, the transfer completes that cycle, and `result_valid`/`busy` are 0 at t+6.
- A new `fc2_done` is accepted from the first IDLE cycle, i.e. the cycle after the handshake. `fc2_done` in the handshake cycle itself counts as an overrun.
- `sram_raddr_f` holds its last value outside READ.

## Structure
- Shared package `lenet_pkg`:
  - CLASS_NUM, DATA_WIDTH, DATA_NUM_PER_SRAM_ADDR.
  - F_WORDS = ceil(CLASS_NUM/DATA_NUM_PER_SRAM_ADDR) = 3.
  - FSM state enum.
- One sub-module `argmax_unit`, instantiated twice (set 0, set 1):
  - Inputs: word, word index, init/enable.
  - Contents: lane masking, 4-lane signed max tree, running max register.
- The top level holds the FSM, address counter, handshake and `overrun`.

## Test plan
- Basic: set 0 scores {0..9} = 10,20,…,100; set 1 = all −5 except class 3 = 7. Pulse `fc2_done`, hold `result_ready`=1 → at t+5: class0=9, score0=100, class1=3, score1=7.
- Signed and ties: set 0 all −128 except classes 2 and 6 = −1 → class0=2, score0=−1. Set 1 all equal 0x7F → class1=0.
- Unused lanes ignored: word 2 lanes 2–3 = 0x7F, all valid scores = 0 → both classes=0, scores=0.
- Backpressure: `result_ready`=0 for 10 cycles after `result_valid` → outputs stable, `busy`=1. Release → `result_valid` drops next cycle. A second `fc2_done` 1 cycle later is accepted, with a new result at +5.
- Overrun: `fc2_done` at t and t+2 → one result only at t+5; `overrun`=1 from t+3 and still 1 after the handshake.
- Reset mid-operation: `srst` at t+3 → next cycle IDLE, `busy`=0, no `result_valid`. A fresh `fc2_done` then gives a correct result 5 cycles later.
